// File: rtl/ins_encoder.sv
// ins_encoder: packs decoded instruction fields into 32-bit words and writes them to successive instruction-memory addresses.
// Ports: clk/rst_n (async active-low); start begins a session at BASE_ADDR; in_valid/in_ready input handshake;
// opcode/func/rs/rt/rd/imm16/imm26 fields; mem_we/mem_addr/mem_wdata registered write port;
// count words written; busy in RUN; done sticky after HALT; err 01 illegal opcode, 10 address overflow.
module ins_encoder #(
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        func,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [31:0] enc;
  logic legal;
  logic halt;
  always_comb begin
    enc = '0;
    legal = 1'b1;
    if (opcode == 6'h00 || opcode == 6'h15) enc = {opcode, rs, rt, rd, 6'b0, func};
    else if (opcode >= 6'h01 && opcode <= 6'h12) enc = {opcode, rs, rt, imm16};
    else if (opcode == 6'h14) enc = {opcode, rs, 5'b0, rd, 11'b0};
    else if (opcode inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h26}) enc = {opcode, imm26};
    else if (opcode == 6'h24 || opcode == 6'h25) enc = {opcode, 26'b0};
    else legal = 1'b0;
  end
  assign halt = opcode == 6'h24;
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= ADDR_W'(BASE_ADDR);
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      count <= '0;
      done <= 1'b0;
      err <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      if (state != RUN) begin
        if (start) begin
          state <= RUN;
          addr <= ADDR_W'(BASE_ADDR);
          count <= '0;
          done <= 1'b0;
          err <= 2'b00;
        end
      end else if (in_valid) begin
        if (!legal) begin
          state <= ERR;
          err <= 2'b01;
        end else begin
          mem_we <= 1'b1;
          mem_addr <= addr;
          mem_wdata <= enc;
          count <= count + 1'b1;
          // HALT at the last address still finishes cleanly; any other word there exhausts the space
          if (halt) begin
            state <= DONE;
            done <= 1'b1;
          end else if (&addr) begin
            state <= ERR;
            err <= 2'b10;
          end else addr <= addr + 1'b1;
        end
      end
    end
  end
endmodule
